// File: rtl/iir_sos_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// iir_sos_sequencer
//
// Time-multiplexed 6th-order IIR filter built from three cascaded Direct Form II
// biquad sections. One multiplier and one accumulator are shared by all three
// sections. A state machine steps through each section's coefficients. A small
// register file holds the coefficients and the per-section delay states.
//
// Per section (s = section input, w = new delay value):
//   FB1 : acc  = (s <<< CFL) - a1*w1
//   FB2 : acc -= a2*w2
//   WC  : w    = sat(acc >>> CFL)
//   FF0 : acc  = b0*w
//   FF1 : acc += b1*w1
//   FF2 : acc += b2*w2
//   UPD : out  = sat(acc >>> CFL); w2 <= w1; w1 <= w
// After the last section, OUT registers y. A sample accepted on edge E0 gives
// y_valid on edge E0+22.
//
// Build option:
//   IIR_SEQ_ROUND_EN  defined   -> round-half-up (add 2^(CFL-1) before >>> CFL)
//                     undefined -> truncation (floor)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   x         in   input sample (signed Q15.13)
//   x_valid   in   input sample valid
//   x_ready   out  block can accept a sample
//   y         out  filtered output sample
//   y_valid   out  output valid, held until y_ready
//   y_ready   in   consumer accepts y
//   cfg_we    in   coefficient write strobe
//   cfg_addr  in   coefficient index = sec*5 + {b0,b1,b2,a1,a2}; 15 reserved
//   cfg_data  in   coefficient value (signed Q2.14)
//   cfg_err   out  one-cycle pulse: a write was rejected
//   flush     in   clear all delay states (deferred while busy)
//   busy      out  FSM not in IDLE
//   sat_flag  out  sticky saturation indicator, cleared by reset or flush
// -----------------------------------------------------------------------------
module iir_sos_sequencer #(
  parameter int WL   = 28,
  parameter int CWL  = 16,
  parameter int CFL  = 14,
  parameter int NSEC = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [WL-1:0]  x,
  input  logic                  x_valid,
  output logic                  x_ready,
  output logic signed [WL-1:0]  y,
  output logic                  y_valid,
  input  logic                  y_ready,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_addr,
  input  logic signed [CWL-1:0] cfg_data,
  output logic                  cfg_err,
  input  logic                  flush,
  output logic                  busy,
  output logic                  sat_flag
);

  localparam int ACCW  = WL + CWL + 3;
  localparam int NCOEF = NSEC * 5;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_FB1  = 4'd1;
  localparam logic [3:0] S_FB2  = 4'd2;
  localparam logic [3:0] S_WC   = 4'd3;
  localparam logic [3:0] S_FF0  = 4'd4;
  localparam logic [3:0] S_FF1  = 4'd5;
  localparam logic [3:0] S_FF2  = 4'd6;
  localparam logic [3:0] S_UPD  = 4'd7;
  localparam logic [3:0] S_OUT  = 4'd8;

  localparam logic signed [CWL-1:0] COEF_ONE = CWL'(1 << CFL);
  localparam logic signed [WL-1:0]  SAT_MAX  = {1'b0, {(WL-1){1'b1}}};
  localparam logic signed [WL-1:0]  SAT_MIN  = {1'b1, {(WL-1){1'b0}}};

  // Coefficient offsets inside one section's group of five.
  localparam logic [3:0] OFS_B0 = 4'd0;
  localparam logic [3:0] OFS_B1 = 4'd1;
  localparam logic [3:0] OFS_B2 = 4'd2;
  localparam logic [3:0] OFS_A1 = 4'd3;
  localparam logic [3:0] OFS_A2 = 4'd4;

  logic [3:0]             state_q, state_d;
  logic [1:0]             sec_q, sec_d;          // wide enough for NSEC = 3
  logic signed [WL-1:0]   s_q, s_d;              // current section input / output
  logic signed [WL-1:0]   w_q, w_d;              // new delay value of current section
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [WL-1:0]   y_q, y_d;
  logic                   y_valid_q, y_valid_d;
  logic                   cfg_err_q;
  logic                   sat_flag_q;
  logic                   flush_pend_q;

  logic signed [CWL-1:0]  coef_q [NCOEF];
  logic signed [WL-1:0]   w1_q   [NSEC];
  logic signed [WL-1:0]   w2_q   [NSEC];

  // ---------------------------------------------------------------------------
  // Control qualifiers
  // ---------------------------------------------------------------------------
  logic cfg_ok;
  logic flush_now;
  logic sat_set;

  assign x_ready   = (state_q == S_IDLE) && !y_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign cfg_ok    = cfg_we && (state_q == S_IDLE) && (cfg_addr <= 4'(NCOEF - 1));
  // A flush raised while busy is remembered and applied once back in IDLE,
  // so the in-flight sample still sees its old delay states.
  assign flush_now = (state_q == S_IDLE) && (flush || flush_pend_q);

  // ---------------------------------------------------------------------------
  // Shared multiplier operand selection
  // ---------------------------------------------------------------------------
  logic [3:0]            coef_base;
  logic signed [CWL-1:0] mul_c;
  logic signed [WL-1:0]  mul_d;
  logic signed [WL-1:0]  w1_cur;
  logic signed [WL-1:0]  w2_cur;

  assign coef_base = 4'(sec_q) * 4'd5;
  assign w1_cur    = w1_q[sec_q];
  assign w2_cur    = w2_q[sec_q];

  always_comb begin
    mul_c = '0;
    mul_d = '0;
    case (state_q)
      S_FB1: begin mul_c = coef_q[coef_base + OFS_A1]; mul_d = w1_cur; end
      S_FB2: begin mul_c = coef_q[coef_base + OFS_A2]; mul_d = w2_cur; end
      S_FF0: begin mul_c = coef_q[coef_base + OFS_B0]; mul_d = w_q;    end
      S_FF1: begin mul_c = coef_q[coef_base + OFS_B1]; mul_d = w1_cur; end
      S_FF2: begin mul_c = coef_q[coef_base + OFS_B2]; mul_d = w2_cur; end
      default: begin mul_c = '0; mul_d = '0; end
    endcase
  end

  // Both operands are sign-extended to accumulator width so the product is
  // exact (it needs only WL+CWL bits).
  logic signed [ACCW-1:0] mul_c_ext;
  logic signed [ACCW-1:0] mul_d_ext;
  logic signed [ACCW-1:0] prod;
  logic signed [ACCW-1:0] s_shift;

  assign mul_c_ext = ACCW'(mul_c);
  assign mul_d_ext = ACCW'(mul_d);
  assign prod      = mul_c_ext * mul_d_ext;
  assign s_shift   = ACCW'(s_q) <<< CFL;

  // ---------------------------------------------------------------------------
  // Rescale and saturate (shared by WC and UPD, both read acc_q)
  // ---------------------------------------------------------------------------
  logic signed [ACCW-1:0] acc_rnd;
  logic signed [ACCW-1:0] acc_shr;
  logic                   sat_ovf;
  logic signed [WL-1:0]   sat_val;

`ifdef IIR_SEQ_ROUND_EN
  localparam logic signed [ACCW-1:0] RND_HALF = ACCW'(1 << (CFL - 1));
  assign acc_rnd = acc_q + RND_HALF;
`else
  assign acc_rnd = acc_q;
`endif

  assign acc_shr = acc_rnd >>> CFL;
  // The value fits in WL bits only if all bits from WL-1 upward agree.
  assign sat_ovf = !((&acc_shr[ACCW-1:WL-1]) || !(|acc_shr[ACCW-1:WL-1]));
  assign sat_val = sat_ovf ? (acc_shr[ACCW-1] ? SAT_MIN : SAT_MAX) : acc_shr[WL-1:0];
  assign sat_set = ((state_q == S_WC) || (state_q == S_UPD)) && sat_ovf;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    acc_d     = acc_q;
    s_d       = s_q;
    w_d       = w_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;

    if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (x_valid && x_ready) begin
          s_d     = x;
          sec_d   = '0;
          state_d = S_FB1;
        end
      end
      S_FB1: begin acc_d = s_shift - prod; state_d = S_FB2; end
      S_FB2: begin acc_d = acc_q - prod;   state_d = S_WC;  end
      S_WC:  begin w_d   = sat_val;        state_d = S_FF0; end
      S_FF0: begin acc_d = prod;           state_d = S_FF1; end
      S_FF1: begin acc_d = acc_q + prod;   state_d = S_FF2; end
      S_FF2: begin acc_d = acc_q + prod;   state_d = S_UPD; end
      S_UPD: begin
        s_d = sat_val;
        if (sec_q == 2'(NSEC - 1)) begin
          sec_d   = '0;
          state_d = S_OUT;
        end else begin
          sec_d   = sec_q + 2'd1;
          state_d = S_FB1;
        end
      end
      S_OUT: begin
        y_d       = s_q;
        y_valid_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sec_q        <= '0;
      acc_q        <= '0;
      s_q          <= '0;
      w_q          <= '0;
      y_q          <= '0;
      y_valid_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      sat_flag_q   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_q        <= sec_d;
      acc_q        <= acc_d;
      s_q          <= s_d;
      w_q          <= w_d;
      y_q          <= y_d;
      y_valid_q    <= y_valid_d;
      cfg_err_q    <= cfg_we && !cfg_ok;
      sat_flag_q   <= flush_now ? 1'b0 : (sat_flag_q || sat_set);
      flush_pend_q <= flush_now ? 1'b0 : (flush_pend_q || (flush && busy));
    end
  end

  // Coefficient register file; reset value is an identity filter (b0 = 1.0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCOEF; i++) begin
        coef_q[i] <= ((i % 5) == 0) ? COEF_ONE : '0;
      end
    end else if (cfg_ok) begin
      coef_q[cfg_addr] <= cfg_data;
    end
  end

  // Per-section delay states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSEC; i++) begin
        w1_q[i] <= '0;
        w2_q[i] <= '0;
      end
    end else if (flush_now) begin
      for (int i = 0; i < NSEC; i++) begin
        w1_q[i] <= '0;
        w2_q[i] <= '0;
      end
    end else if (state_q == S_UPD) begin
      w2_q[sec_q] <= w1_q[sec_q];
      w1_q[sec_q] <= w_q;
    end
  end

  assign y        = y_q;
  assign y_valid  = y_valid_q;
  assign cfg_err  = cfg_err_q;
  assign sat_flag = sat_flag_q;

endmodule
